spi_word_sequencer: RTL

- Feeds `simple_spi_master` from the upstream side: takes a valid/ready stream of TX words with frame delimiters and drives the master's `xfer_enable`, `xfer_word_trigger` and `data_tx`.
- Collects each `data_rx` on `xfer_word_completed` into a small RX FIFO, presented as a valid/ready stream.
- Sets CS setup/hold/gap timing in system clocks.
- Gives flow control in both directions, so a frame never stalls mid-word.

---
 rtl/spi_word_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spi_word_sequencer.sv
// Upstream framer for simple_spi_master: turns a framed TX word stream into
// enable/trigger sequencing with CS setup/hold/gap timing, and buffers RX words.
module spi_word_sequencer #(
  parameter int WORDWIDTH     = 8,
  parameter int RX_DEPTH_LOG2 = 2,
  parameter int CS_SETUP_CLKS = 2,
  parameter int CS_HOLD_CLKS  = 2,
  parameter int CS_GAP_CLKS   = 2
) (
  input  logic                 system_clk,
  input  logic                 system_rst_n,
  input  logic [WORDWIDTH-1:0] tx_data,
  input  logic                 tx_last,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [WORDWIDTH-1:0] rx_data,
  output logic                 rx_last,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 spi_xfer_enable,
  output logic                 spi_xfer_word_trigger,
  input  logic                 spi_xfer_word_completed,
  output logic [WORDWIDTH-1:0] spi_data_tx,
  input  logic [WORDWIDTH-1:0] spi_data_rx
);

  localparam int DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int CNT_W = 16;
  localparam logic [RX_DEPTH_LOG2:0] FULL_CNT = (RX_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, SETUP, TRIG, BUSY, WAIT_NEXT, HOLD, GAP
  } state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     alive;
  logic                     last_reg;
  logic                     accept_state;
  logic                     accept;
  logic                     push, pop;
  logic [RX_DEPTH_LOG2:0]   count;
  logic [RX_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [WORDWIDTH:0]       mem [DEPTH];

  // State register
  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; cnt holds the remaining cycles of SETUP/HOLD/GAP
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          cnt_nxt   = CNT_W'(CS_SETUP_CLKS);
        end
      end
      SETUP: begin
        if (cnt <= CNT_W'(1)) state_nxt = TRIG;
        else                  cnt_nxt   = cnt - CNT_W'(1);
      end
      TRIG: state_nxt = BUSY;
      BUSY: begin
        if (spi_xfer_word_completed) begin
          if (last_reg) begin
            state_nxt = HOLD;
            cnt_nxt   = CNT_W'(CS_HOLD_CLKS);
          end else begin
            state_nxt = WAIT_NEXT;
          end
        end
      end
      WAIT_NEXT: begin
        if (accept) state_nxt = TRIG;
      end
      HOLD: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = GAP;
          cnt_nxt   = CNT_W'(CS_GAP_CLKS);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt <= CNT_W'(1)) state_nxt = IDLE;
        else                  cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from state only
  always_comb begin
    spi_xfer_enable       = 1'b0;
    spi_xfer_word_trigger = 1'b0;
    accept_state          = 1'b0;
    case (state)
      IDLE:      accept_state = 1'b1;
      SETUP:     spi_xfer_enable = 1'b1;
      TRIG: begin
        spi_xfer_enable       = 1'b1;
        spi_xfer_word_trigger = 1'b1;
      end
      BUSY:      spi_xfer_enable = 1'b1;
      WAIT_NEXT: begin
        spi_xfer_enable = 1'b1;
        accept_state    = 1'b1;
      end
      HOLD:      spi_xfer_enable = 1'b1;
      default:   ;
    endcase
  end

  // Only one word is ever in flight, so a free slot at accept guarantees room for its RX word
  assign tx_ready = alive && accept_state && (count != FULL_CNT);
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state != IDLE);

  // TX word latch and post-reset alive flag
  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      alive       <= 1'b0;
      spi_data_tx <= '0;
      last_reg    <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (accept) begin
        spi_data_tx <= tx_data;
        last_reg    <= tx_last;
      end
    end
  end

  // RX FIFO, first-word-fall-through
  assign push     = (state == BUSY) && spi_xfer_word_completed;
  assign pop      = rx_valid && rx_ready;
  assign rx_valid = (count != '0);

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + RX_DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + RX_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + (RX_DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (RX_DEPTH_LOG2 + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge system_clk) begin
    if (push) mem[wr_ptr] <= {spi_data_rx, last_reg};
  end

  // Head is masked when empty so stale storage never shows on rx_data/rx_last
  assign {rx_data, rx_last} = rx_valid ? mem[rd_ptr] : '0;

endmodule
